// File: rtl/vfpm_pkg.sv
// Shared types and constants for the vector FP multiply scheduler.
package vfpm_pkg;

    localparam int FP_W        = 32;
    localparam int DEF_LANES   = 4;
    localparam int DEF_MUL_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vfpm_state_e;

    // Bit offset of a lane inside a packed vector.
    function automatic int lane_lsb(input int lane);
        return lane * FP_W;
    endfunction

endpackage

// File: rtl/vfpm_tag_pipe.sv
// Lane-tag delay line matching the shared multiplier latency; a flush clears every stage.
module vfpm_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             vld_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    // Shift the issued lane tag one stage per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else if (clr_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
            vld_q[0] <= vld_i;
            idx_q[0] <= idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign idx_o = idx_q[DEPTH-1];

endmodule

// File: rtl/vec_mul_sched.sv
// Serialises a vector pair onto one shared FP multiplier, one lane per cycle,
// and reassembles the lane results into a result vector.
module vec_mul_sched
    import vfpm_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FP_W*LANES-1:0] a_vec,
    input  logic [FP_W*LANES-1:0] b_vec,
    input  logic                  flush,
    output logic                  mul_start,
    output logic [FP_W-1:0]       mul_a,
    output logic [FP_W-1:0]       mul_b,
    input  logic [FP_W-1:0]       mul_c,
    input  logic                  mul_e,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FP_W*LANES-1:0] c_vec,
    output logic [LANES-1:0]      e_vec,
    output logic                  any_e,
    output logic                  busy
);

    localparam int IDX_W = $clog2(LANES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    vfpm_state_e           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [FP_W*LANES-1:0] a_q, b_q, c_q;
    logic [LANES-1:0]      e_q;
    logic                  accept_s, issue_s, capture_s, tag_vld_s;
    logic [IDX_W-1:0]      issue_idx_s, tag_idx_s;

    assign accept_s    = (state_q == ST_IDLE) && in_valid && !flush;
    assign issue_s     = (state_q == ST_ISSUE);
    assign issue_idx_s = cnt_q[IDX_W-1:0];
    assign capture_s   = tag_vld_s && !flush;
    assign c_vec       = c_q;
    assign e_vec       = e_q;

    vfpm_tag_pipe #(
        .DEPTH (MUL_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (flush),
        .vld_i (issue_s),
        .idx_i (issue_idx_s),
        .vld_o (tag_vld_s),
        .idx_o (tag_idx_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (in_valid) state_d = ST_ISSUE; else state_d = ST_IDLE;
                ST_ISSUE: if (cnt_q == LAST_CNT) state_d = ST_DRAIN; else state_d = ST_ISSUE;
                ST_DRAIN: if (tag_vld_s && (tag_idx_s == LAST_IDX)) state_d = ST_DONE;
                          else state_d = ST_DRAIN;
                ST_DONE:  if (out_ready) state_d = ST_IDLE; else state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs; operands are zeroed whenever nothing is issuing.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        mul_start = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        out_valid = 1'b0;
        any_e     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_ISSUE: begin
                mul_start = 1'b1;
                mul_a     = a_q[lane_lsb(int'(issue_idx_s)) +: FP_W];
                mul_b     = b_q[lane_lsb(int'(issue_idx_s)) +: FP_W];
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                any_e     = |e_q;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b1;
            end
        endcase
    end

    // Operand capture, issue counter (saturates at the last lane) and result assembly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            e_q   <= '0;
            cnt_q <= '0;
        end else if (accept_s) begin
            a_q   <= a_vec;
            b_q   <= b_vec;
            c_q   <= '0;
            e_q   <= '0;
            cnt_q <= '0;
        end else begin
            if (issue_s && !flush && (cnt_q != LAST_CNT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture_s) begin
                c_q[lane_lsb(int'(tag_idx_s)) +: FP_W] <= mul_c;
                e_q[tag_idx_s]                         <= mul_e;
            end
        end
    end

endmodule

// File: tb/tb_vec_mul_sched.sv
// Randomised bench for vec_mul_sched with an ideal fixed-latency multiplier
// and a lane-wise FP reference model.
module tb_vec_mul_sched;
    import vfpm_pkg::*;

    localparam int LANES   = 4;
    localparam int MUL_LAT = 3;
    localparam int VW      = FP_W * LANES;
    localparam int LAT     = LANES + MUL_LAT + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic [VW-1:0]    a_vec = '0;
    logic [VW-1:0]    b_vec = '0;
    logic             in_ready, mul_start, out_valid, any_e, busy, mul_e;
    logic [31:0]      mul_a, mul_b, mul_c;
    logic [VW-1:0]    c_vec;
    logic [LANES-1:0] e_vec;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vec_mul_sched #(.LANES(LANES), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .flush     (flush),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .mul_e     (mul_e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_vec     (c_vec),
        .e_vec     (e_vec),
        .any_e     (any_e),
        .busy      (busy)
    );

    // Ideal FP32 multiply for normal operands; returns {overflow, result}.
    function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ex;
        logic [47:0] p;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        ex = int'(a[30:23]) + int'(b[30:23]) - 127;
        p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        if (p[47]) begin
            m  = p[46:24];
            ex = ex + 1;
        end else begin
            m  = p[45:23];
        end
        if (ex >= 255) return {1'b1, s, 8'hFF, 23'h0};
        return {1'b0, s, ex[7:0], m};
    endfunction

    logic [32:0]        mp_q [MUL_LAT];
    logic [MUL_LAT-1:0] mv_q = '0;
    logic [31:0]        junk_q = 32'h0;

    // Multiplier model: result appears MUL_LAT cycles after the start cycle, junk otherwise.
    always @(posedge clk) begin
        mv_q[0] <= mul_start;
        mp_q[0] <= fp_mul(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT; i++) begin
            mv_q[i] <= mv_q[i-1];
            mp_q[i] <= mp_q[i-1];
        end
        junk_q <= $urandom;
    end

    assign mul_c = mv_q[MUL_LAT-1] ? mp_q[MUL_LAT-1][31:0] : junk_q;
    assign mul_e = mv_q[MUL_LAT-1] ? mp_q[MUL_LAT-1][32]   : junk_q[0];

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)),
                8'($urandom_range(0, 255)), 15'h0};
    endfunction

    task automatic rand_vec(output logic [VW-1:0] v);
        for (int i = 0; i < LANES; i++) v[i*FP_W +: FP_W] = rand_fp();
    endtask

    task automatic ref_vec(input logic [VW-1:0] a, input logic [VW-1:0] b,
                           output logic [VW-1:0] c, output logic [LANES-1:0] e);
        logic [32:0] r;
        for (int i = 0; i < LANES; i++) begin
            r = fp_mul(a[i*FP_W +: FP_W], b[i*FP_W +: FP_W]);
            c[i*FP_W +: FP_W] = r[31:0];
            e[i] = r[32];
        end
    endtask

    // One vector: accept, latency, optional backpressure of 'hold' cycles, result, release.
    task automatic run_vec(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b,
                           input logic [VW-1:0] ec, input logic [LANES-1:0] ee, input int hold);
        int n;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin tick; w++; end
        check_eq({tag, "_rdy"}, VW'(in_ready), VW'(1));
        out_ready = (hold == 0);
        a_vec     = a;
        b_vec     = b;
        in_valid  = 1'b1;
        tick;
        in_valid  = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin tick; n++; end
        check_eq({tag, "_lat"}, VW'(n), VW'(LAT));
        for (int h = 0; h < hold; h++) begin
            check_eq({tag, "_hold_ov_ir"}, VW'({out_valid, in_ready}), VW'(2'b10));
            check_eq({tag, "_hold_c"}, c_vec, ec);
            tick;
        end
        check_eq({tag, "_c"}, c_vec, ec);
        check_eq({tag, "_e"}, VW'(e_vec), VW'(ee));
        check_eq({tag, "_any_ov"}, VW'({any_e, out_valid}), VW'({|ee, 1'b1}));
        out_ready = 1'b1;
        tick;
        check_eq({tag, "_release"}, VW'({out_valid, in_ready}), VW'(2'b01));
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0]    va, vb, va2, vb2, ec, ec2;
        logic [LANES-1:0] ee, ee2;
        logic             ms [20];
        logic             ir [20];
        logic             ov [20];
        logic [VW-1:0]    cq [$];
        logic [9:0]       pat;
        int               first_ov, acc2, ov_cnt;

        #12;
        check_eq("rst_ctl", VW'({in_ready, busy, mul_start, out_valid, any_e, e_vec}), VW'(9'b1_0000_0000));
        check_eq("rst_data", c_vec, '0);
        check_eq("rst_ops", VW'({mul_a, mul_b}), '0);
        @(negedge clk);
        reset = 1'b1;
        tick;

        va = {32'h3F000000, 32'hC0400000, 32'h40000000, 32'h3F800000};
        vb = {32'h40800000, 32'h40000000, 32'h40000000, 32'h40000000};
        run_vec("basic", va, vb, {32'h40000000, 32'hC0C00000, 32'h40800000, 32'h40000000}, 4'b0000, 0);

        va = {32'h3F800000, 32'h7F000000, 32'h40000000, 32'h3F800000};
        vb = {32'h40000000, 32'h7F000000, 32'h40400000, 32'h40000000};
        ref_vec(va, vb, ec, ee);
        check_eq("ovf_lane0", VW'(ec[31:0]), VW'(32'h40000000));
        run_vec("ovf", va, vb, ec, 4'b0100, 0);

        for (int i = 0; i < 6; i++) begin
            rand_vec(va);
            rand_vec(vb);
            ref_vec(va, vb, ec, ee);
            run_vec("rand", va, vb, ec, ee, int'($urandom_range(0, 3)));
        end

        rand_vec(va);
        rand_vec(vb);
        ref_vec(va, vb, ec, ee);
        run_vec("bp", va, vb, ec, ee, 5);

        // Flush while lane 1 is being issued.
        rand_vec(va);
        rand_vec(vb);
        a_vec = va;
        b_vec = vb;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check_eq("fl_lane0", VW'({mul_start, mul_a, mul_b}), VW'({1'b1, va[31:0], vb[31:0]}));
        tick;
        check_eq("fl_lane1", VW'({mul_start, mul_a}), VW'({1'b1, va[63:32]}));
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check_eq("fl_idle", VW'({in_ready, busy, out_valid, mul_start}), VW'(4'b1000));
        rand_vec(va);
        rand_vec(vb);
        ref_vec(va, vb, ec, ee);
        run_vec("post_fl", va, vb, ec, ee, 0);

        // Reset pulse while draining.
        rand_vec(va);
        rand_vec(vb);
        a_vec = va;
        b_vec = vb;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check_eq("drain_busy", VW'({busy, in_ready, mul_start}), VW'(3'b100));
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_ctl", VW'({in_ready, busy, mul_start, out_valid, any_e, e_vec}), VW'(9'b1_0000_0000));
        check_eq("arst_data", c_vec, '0);
        check_eq("arst_ops", VW'({mul_a, mul_b}), '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick;
        check_eq("post_rst_idle", VW'({in_ready, busy}), VW'(2'b10));
        ov_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) ov_cnt++;
            tick;
        end
        check_eq("post_rst_no_ov", VW'(ov_cnt), '0);
        rand_vec(va);
        rand_vec(vb);
        ref_vec(va, vb, ec, ee);
        run_vec("post_rst", va, vb, ec, ee, 0);

        // Back-to-back with in_valid held and out_ready high.
        rand_vec(va);
        rand_vec(vb);
        rand_vec(va2);
        rand_vec(vb2);
        ref_vec(va, vb, ec, ee);
        ref_vec(va2, vb2, ec2, ee2);
        a_vec = va;
        b_vec = vb;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ms[k] = mul_start;
            ir[k] = in_ready;
            ov[k] = out_valid;
            if (out_valid) cq.push_back(c_vec);
            if (k == 1) begin
                a_vec = va2;
                b_vec = vb2;
            end
            if (k == 10) in_valid = 1'b0;
            tick;
        end
        out_ready = 1'b0;
        first_ov = -1;
        acc2 = -1;
        pat = 10'b0;
        for (int k = 19; k >= 0; k--) if (ov[k]) first_ov = k;
        for (int k = 19; k >= 1; k--) if (ir[k]) acc2 = k;
        for (int k = 1; k <= 10; k++) pat = {pat[8:0], ms[k]};
        check_eq("b2b_first_ov", VW'(first_ov), VW'(LAT));
        check_eq("b2b_second_acc", VW'(acc2), VW'(LAT + 1));
        check_eq("b2b_start_pat", VW'({ms[0], pat}), VW'(11'b0_1111000001));
        check_eq("b2b_nres", VW'(cq.size()), VW'(2));
        if (cq.size() >= 2) begin
            check_eq("b2b_res0", cq[0], ec);
            check_eq("b2b_res1", cq[1], ec2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
